// File: rtl/gate_seq_pkg.sv
// Shared types for the gate burst sequencer: FSM state encoding and
// shadow-register select codes.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StWait,
    StDrain
  } seq_state_e;

  localparam logic SEL_DELAY = 1'b0;
  localparam logic SEL_WIDTH = 1'b1;

endpackage

// File: rtl/seq_period_timer.sv
// Load/decrement down-counter used to space triggers. expire is high when the
// current decrement brings the count to zero.
module seq_period_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire = (count_q <= W'(1));

endmodule

// File: rtl/gate_burst_sequencer.sv
// Burst controller for a bank of gate-delay pulse channels: shadow/active
// delay-width banks, periodic trigger issue, busy monitoring and overrun.
module gate_burst_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 32,
  parameter int unsigned CW   = 16,
  parameter int unsigned CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic              cfg_sel,
  input  logic [W-1:0]      cfg_data,
  input  logic [W-1:0]      period,
  input  logic [CW-1:0]     burst_len,
  input  logic [N_CH-1:0]   ch_enable,
  input  logic              start,
  input  logic              abort,
  input  logic [N_CH-1:0]   ch_busy,
  output logic [N_CH-1:0]   ch_trigger,
  output logic [N_CH*W-1:0] ch_delay,
  output logic [N_CH*W-1:0] ch_width,
  output logic              running,
  output logic              done,
  output logic              overrun,
  output logic [CW-1:0]     shot_count
);

  seq_state_e      state_q;
  logic [W-1:0]    period_q;
  logic [CW-1:0]   len_q;
  logic [N_CH-1:0] mask_q;
  logic [CW-1:0]   shot_next;
  logic            start_accept;
  logic            tmr_expire;
  logic            busy_hit;

  assign start_accept = !abort && (state_q == StIdle) && start &&
                        (burst_len != '0) && (period != '0);
  assign shot_next    = shot_count + CW'(1);
  assign busy_hit     = ((ch_busy & mask_q) != '0);

  // Shadow writes land every cycle; the active copy only moves on an accepted
  // start, and sees the shadow value from before that edge.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] sh_delay_q, sh_width_q, act_delay_q, act_width_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_delay_q  <= '0;
        sh_width_q  <= '0;
        act_delay_q <= '0;
        act_width_q <= '0;
      end else begin
        if (cfg_we && (cfg_ch == CHW'(i))) begin
          if (cfg_sel == SEL_DELAY) sh_delay_q <= cfg_data;
          else                      sh_width_q <= cfg_data;
        end
        if (start_accept) begin
          act_delay_q <= sh_delay_q;
          act_width_q <= sh_width_q;
        end
      end
    end

    assign ch_delay[i*W +: W] = act_delay_q;
    assign ch_width[i*W +: W] = act_width_q;
  end

  seq_period_timer #(
    .W (W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == StFire),
    .load_val (period_q - W'(1)),
    .dec      (state_q == StWait),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      period_q   <= '0;
      len_q      <= '0;
      mask_q     <= '0;
      ch_trigger <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      shot_count <= '0;
    end else begin
      done       <= 1'b0;
      ch_trigger <= '0;
      if (abort) begin
        state_q <= StIdle;
        running <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_accept) begin
              period_q   <= period;
              len_q      <= burst_len;
              mask_q     <= ch_enable;
              shot_count <= '0;
              overrun    <= 1'b0;
              running    <= 1'b1;
              state_q    <= StFire;
            end else if (start) begin
              done <= 1'b1;
            end
          end
          StFire: begin
            ch_trigger <= mask_q;
            shot_count <= shot_next;
            if (busy_hit) overrun <= 1'b1;
            if (period_q == W'(1)) state_q <= (shot_next < len_q) ? StFire : StDrain;
            else                   state_q <= StWait;
          end
          StWait: begin
            if (tmr_expire) state_q <= (shot_count < len_q) ? StFire : StDrain;
          end
          StDrain: begin
            if (!busy_hit) begin
              done    <= 1'b1;
              running <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_burst_sequencer.sv
// Self-checking bench for gate_burst_sequencer: expected triggers are queued
// when a burst is started and popped as the DUT emits them.
module tb_gate_burst_sequencer;

  localparam int N_CH = 4;
  localparam int W    = 32;
  localparam int CW   = 16;
  localparam int CHW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CHW-1:0]    cfg_ch = '0;
  logic              cfg_sel = 1'b0;
  logic [W-1:0]      cfg_data = '0;
  logic [W-1:0]      period = '0;
  logic [CW-1:0]     burst_len = '0;
  logic [N_CH-1:0]   ch_enable = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [N_CH-1:0]   ch_busy = '0;
  logic [N_CH-1:0]   ch_trigger;
  logic [N_CH*W-1:0] ch_delay;
  logic [N_CH*W-1:0] ch_width;
  logic              running;
  logic              done;
  logic              overrun;
  logic [CW-1:0]     shot_count;

  gate_burst_sequencer #(
    .N_CH (N_CH),
    .W    (W),
    .CW   (CW),
    .CHW  (CHW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .period     (period),
    .burst_len  (burst_len),
    .ch_enable  (ch_enable),
    .start      (start),
    .abort      (abort),
    .ch_busy    (ch_busy),
    .ch_trigger (ch_trigger),
    .ch_delay   (ch_delay),
    .ch_width   (ch_width),
    .running    (running),
    .done       (done),
    .overrun    (overrun),
    .shot_count (shot_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] mask;
  } trig_t;

  trig_t exp_q[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    total = 0;
  int    bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Trigger scoreboard and done counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ch_trigger != '0) begin
      if (exp_q.size() == 0) begin
        check_val("trig_unexpected", 64'(ch_trigger), 64'h0);
      end else begin
        trig_t e;
        e = exp_q.pop_front();
        check_val("trig_cycle", 64'(cyc), 64'(e.cyc));
        check_val("trig_mask", 64'(ch_trigger), 64'(e.mask));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic cfg_write(input int ch, input logic sel, input logic [W-1:0] data);
    cfg_we   = 1'b1;
    cfg_ch   = CHW'(ch);
    cfg_sel  = sel;
    cfg_data = data;
    step();
    cfg_we   = 1'b0;
  endtask

  // Pulses start for one cycle and queues n expected triggers.
  task automatic start_burst(input logic [N_CH-1:0] mask, input int per, input int len,
                             input int n, output int c0);
    ch_enable = mask;
    period    = W'(per);
    burst_len = CW'(len);
    c0        = cyc;
    for (int k = 0; k < n; k++) begin
      trig_t e;
      e.cyc  = c0 + 2 + k * per;
      e.mask = mask;
      exp_q.push_back(e);
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check_val({tag, "_done_seen"}, 64'(done_cnt != d0), 64'h1);
    repeat (4) step();
    check_val({tag, "_done_once"}, 64'(done_cnt - d0), 64'h1);
  endtask

  initial begin
    int c0;
    int d0;

    repeat (3) step();
    check_val("rst_running", 64'(running), 64'h0);
    check_val("rst_trigger", 64'(ch_trigger), 64'h0);
    check_val("rst_shots", 64'(shot_count), 64'h0);
    check_val("rst_delay", 64'(ch_delay), 64'h0);
    rst_n = 1'b1;
    step();

    // Basic burst with shadow values, a mid-burst write and a busy drain.
    cfg_write(0, 1'b0, 32'd10);
    cfg_write(0, 1'b1, 32'd5);
    start_burst(4'b0001, 8, 3, 3, c0);
    @(negedge clk);
    check_val("b1_delay", 64'(ch_delay[31:0]), 64'd10);
    check_val("b1_width", 64'(ch_width[31:0]), 64'd5);
    check_val("b1_running", 64'(running), 64'h1);
    wait_until(c0 + 5);
    cfg_write(0, 1'b0, 32'd77);
    wait_until(c0 + 19);
    ch_busy = 4'b0001;
    d0 = done_cnt;
    wait_until(c0 + 30);
    check_val("b1_drain_running", 64'(running), 64'h1);
    check_val("b1_drain_nodone", 64'(done_cnt - d0), 64'h0);
    ch_busy = 4'b0000;
    wait_done("b1", 20);
    check_val("b1_shots", 64'(shot_count), 64'd3);
    check_val("b1_overrun", 64'(overrun), 64'h0);
    check_val("b1_delay_hold", 64'(ch_delay[31:0]), 64'd10);
    check_val("b1_idle", 64'(running), 64'h0);

    // period == 1: back-to-back triggers on every channel.
    start_burst(4'b1111, 1, 4, 4, c0);
    wait_done("b2", 20);
    check_val("b2_shots", 64'(shot_count), 64'd4);
    check_val("b2_delay", 64'(ch_delay[31:0]), 64'd77);

    // Busy during the second FIRE sets a sticky overrun.
    start_burst(4'b0010, 4, 3, 3, c0);
    wait_until(c0 + 3);
    check_val("b3_no_overrun", 64'(overrun), 64'h0);
    wait_until(c0 + 5);
    ch_busy = 4'b0010;
    step();
    ch_busy = 4'b0000;
    check_val("b3_overrun", 64'(overrun), 64'h1);
    wait_done("b3", 30);
    check_val("b3_overrun_sticky", 64'(overrun), 64'h1);
    check_val("b3_shots", 64'(shot_count), 64'd3);

    // Abort after two of five shots, with start in the same cycle.
    start_burst(4'b0100, 4, 5, 2, c0);
    @(negedge clk);
    check_val("b4_overrun_clr", 64'(overrun), 64'h0);
    wait_until(c0 + 3);
    burst_len = CW'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_until(c0 + 7);
    d0 = done_cnt;
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_val("b4_running", 64'(running), 64'h0);
    check_val("b4_shots", 64'(shot_count), 64'd2);
    repeat (20) step();
    check_val("b4_nodone", 64'(done_cnt - d0), 64'h0);
    check_val("b4_still_idle", 64'(running), 64'h0);

    // Degenerate starts: done only, no triggers.
    start_burst(4'b0001, 5, 0, 0, c0);
    check_val("b5_len0_running", 64'(running), 64'h0);
    wait_done("b5_len0", 5);
    start_burst(4'b0001, 0, 3, 0, c0);
    wait_done("b5_per0", 5);
    check_val("b5_shots_hold", 64'(shot_count), 64'd2);

    // Write in the start cycle is not applied; next start picks it up.
    cfg_we   = 1'b1;
    cfg_ch   = 2'd0;
    cfg_sel  = 1'b0;
    cfg_data = 32'd99;
    start_burst(4'b0000, 2, 1, 0, c0);
    cfg_we = 1'b0;
    @(negedge clk);
    check_val("b6_collide", 64'(ch_delay[31:0]), 64'd77);
    wait_done("b6", 10);
    start_burst(4'b0000, 2, 1, 0, c0);
    @(negedge clk);
    check_val("b6_next", 64'(ch_delay[31:0]), 64'd99);
    wait_done("b6b", 10);

    // Asynchronous reset while waiting between shots.
    start_burst(4'b0001, 10, 3, 1, c0);
    wait_until(c0 + 5);
    rst_n = 1'b0;
    #1;
    check_val("rr_running", 64'(running), 64'h0);
    check_val("rr_shots", 64'(shot_count), 64'h0);
    check_val("rr_delay", 64'(ch_delay[31:0]), 64'h0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (40) step();
    check_val("rr_idle", 64'(running), 64'h0);

    check_val("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
